// File: rtl/tq_pkg.sv
// tq_pkg: shared types and helpers for the tq bus checker.
//   tq_chk_state_t  checker FSM state encoding (IDLE..REPORT)
//   TQ_COUNT        default number of words per phase
//   tq_pattern()    deterministic bus pattern for a given word index
package tq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUPPLY,
    SKIP,
    CHECK,
    REPORT
  } tq_chk_state_t;

  localparam int TQ_COUNT = 1000;

  // pattern(i) = i[data_w-1:0] ^ seed ^ i[addr_w-1:data_w], zero-padded.
  // The index is first reduced mod 2**addr_w, so the pattern wraps with the
  // address space. Callers size-cast the 32-bit result down to their data width.
  function automatic logic [31:0] tq_pattern(input logic [31:0] idx,
                                             input logic [31:0] seed,
                                             input int          addr_w,
                                             input int          data_w);
    logic [31:0] dmask;
    logic [31:0] amask;
    logic [31:0] lo;
    logic [31:0] hi;
    dmask = (32'd1 << data_w) - 32'd1;
    amask = (32'd1 << addr_w) - 32'd1;
    lo    = idx & dmask;
    hi    = ((idx & amask) >> data_w) & dmask;
    return (lo ^ seed ^ hi) & dmask;
  endfunction

endpackage

// File: rtl/tq_chk_score.sv
// tq_chk_score: check-phase error scoreboard.
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   clr        clear counters back to the "no errors" state
//   cmp_en     a compare happens this cycle
//   match      result of that compare
//   idx        index of the word being compared
//   err_cnt    saturating mismatch count
//   first_err  index of the first mismatch; all-ones if none
module tq_chk_score #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cmp_en,
  input  logic              match,
  input  logic [ADDR_W-1:0] idx,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err
);

  // A separate "seen" flag is kept because all-ones is also a legal index.
  logic seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      first_err <= '1;
      seen      <= 1'b0;
    end else if (clr) begin
      err_cnt   <= '0;
      first_err <= '1;
      seen      <= 1'b0;
    end else if (cmp_en && !match) begin
      if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (!seen) begin
        seen      <= 1'b1;
        first_err <= idx;
      end
    end
  end

endmodule

// File: rtl/tq_bus_checker.sv
// tq_bus_checker: far-end peer of the tq parallel bus. Supplies a pattern
// for the master to store, then checks the words the master replays and
// reports word/error counts per frame.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   bus_stb     one-cycle bus word qualifier
//   bus_dir     0 = supply (checker drives), 1 = check (master drives)
//   bus_addr    address presented by the master
//   bus_din     data sampled from the bus
//   bus_dout    data driven to the bus (registered)
//   bus_oe      output enable for bus_dout
//   words       words checked in the last completed frame
//   errors      mismatches in the last completed frame (saturating)
//   first_err   index of the first mismatch; all-ones if none
//   seq_err     sticky supply-phase address sequence error
//   done        one-cycle pulse when the report registers update
module tq_bus_checker
  import tq_pkg::*;
#(
  parameter int                ADDR_W = 10,
  parameter int                DATA_W = 8,
  parameter int                COUNT  = TQ_COUNT,
  parameter int                RD_LAT = 2,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_stb,
  input  logic              bus_dir,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_din,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_oe,
  output logic [15:0]       words,
  output logic [15:0]       errors,
  output logic [ADDR_W-1:0] first_err,
  output logic              seq_err,
  output logic              done
);

  localparam int CW = $clog2(COUNT + 1);
  localparam int SW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [CW-1:0] IDX_FULL  = CW'(COUNT);
  localparam logic [CW-1:0] IDX_LAST  = CW'(COUNT - 1);
  localparam logic [SW-1:0] SKIP_LAST = SW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  localparam tq_chk_state_t AFTER_SUPPLY = (RD_LAT == 0) ? CHECK : SKIP;

  tq_chk_state_t     state;
  tq_chk_state_t     state_next;
  logic [CW-1:0]     idx;
  logic [SW-1:0]     skip_cnt;
  logic [ADDR_W-1:0] prev_addr;
  logic              dir_q;

  logic              supply_word;
  logic              skip_adv;
  logic              cmp_en;
  logic              clr;
  logic              match;
  logic              phase_end;

  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] score_first;

  // The master ends a replay either by dropping bus_dir or by strobing with
  // bus_dir low. Edge detection on bus_dir matters: after a full supply
  // phase the checker sits in SKIP while bus_dir is still low.
  assign phase_end = !bus_dir && (bus_stb || dir_q);

  assign match = (bus_din == DATA_W'(tq_pattern(32'(idx), 32'(SEED), ADDR_W, DATA_W)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A strobe arriving on the same cycle bus_dir is first seen high in SUPPLY
  // only turns the phase around; discard counting starts in SKIP.
  always_comb begin
    state_next  = state;
    supply_word = 1'b0;
    skip_adv    = 1'b0;
    cmp_en      = 1'b0;
    clr         = 1'b0;
    case (state)
      IDLE: begin
        if (bus_stb && !bus_dir) begin
          supply_word = 1'b1;
          state_next  = SUPPLY;
        end
      end
      SUPPLY: begin
        if (bus_dir || idx == IDX_FULL) begin
          state_next = AFTER_SUPPLY;
        end else if (bus_stb) begin
          supply_word = 1'b1;
        end
      end
      SKIP: begin
        if (phase_end) begin
          state_next = REPORT;
        end else if (bus_stb) begin
          skip_adv = 1'b1;
          if (skip_cnt == SKIP_LAST) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (phase_end) begin
          state_next = REPORT;
        end else if (bus_stb) begin
          cmp_en = 1'b1;
          if (idx == IDX_LAST) begin
            state_next = REPORT;
          end
        end
      end
      REPORT: begin
        clr        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Supply path, phase counters and report registers. idx counts supply
  // strobes in SUPPLY and accepted compares in CHECK; it is cleared when the
  // supply phase ends and again when the report is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_dout  <= '0;
      bus_oe    <= 1'b0;
      idx       <= '0;
      skip_cnt  <= '0;
      prev_addr <= '0;
      dir_q     <= 1'b0;
      seq_err   <= 1'b0;
      words     <= '0;
      errors    <= '0;
      first_err <= '1;
      done      <= 1'b0;
    end else begin
      dir_q <= bus_dir;
      done  <= 1'b0;

      if (supply_word) begin
        bus_dout  <= DATA_W'(tq_pattern(32'(bus_addr), 32'(SEED), ADDR_W, DATA_W));
        bus_oe    <= 1'b1;
        prev_addr <= bus_addr;
        if (state == IDLE) begin
          idx <= CW'(1);
        end else begin
          idx <= idx + CW'(1);
          if (bus_addr != prev_addr + ADDR_W'(1)) begin
            seq_err <= 1'b1;
          end
        end
      end

      if (state == SUPPLY && state_next != SUPPLY) begin
        bus_oe   <= 1'b0;
        idx      <= '0;
        skip_cnt <= '0;
      end

      if (skip_adv) begin
        skip_cnt <= skip_cnt + SW'(1);
      end

      if (cmp_en) begin
        idx <= idx + CW'(1);
      end

      if (clr) begin
        words     <= 16'(idx);
        errors    <= err_cnt;
        first_err <= score_first;
        done      <= 1'b1;
        idx       <= '0;
      end
    end
  end

  tq_chk_score #(
    .ADDR_W(ADDR_W)
  ) u_score (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .cmp_en   (cmp_en),
    .match    (match),
    .idx      (ADDR_W'(idx)),
    .err_cnt  (err_cnt),
    .first_err(score_first)
  );

endmodule
